// File: rtl/dda_wall_marcher_if.sv
// Ray-setup / result / map-read bundle between the ray setup stage, the DDA marcher and the column renderer.
// With DDA_STATS_EN defined the bundle also carries step_count_out.
interface dda_wall_marcher_if #(
  parameter int MAP_SIZE = 24,
  parameter int ADDR_W   = $clog2(MAP_SIZE * MAP_SIZE)
);
  logic              valid_in;
  logic              ready_out;
  logic [8:0]        hcount_in;
  logic [7:0]        mapX_in;
  logic [7:0]        mapY_in;
  logic              stepX_in;
  logic              stepY_in;
  logic [15:0]       sideDistX_in;
  logic [15:0]       sideDistY_in;
  logic [15:0]       deltaDistX_in;
  logic [15:0]       deltaDistY_in;
  logic [ADDR_W-1:0] map_addr;
  logic [3:0]        map_data;
  logic              valid_out;
  logic              ready_in;
  logic [8:0]        hcount_out;
  logic [3:0]        wall_type_out;
  logic              side_out;
  logic [15:0]       perp_dist_out;
`ifdef DDA_STATS_EN
  logic [7:0]        step_count_out;
`endif

  modport master (
`ifdef DDA_STATS_EN
    input  step_count_out,
`endif
    output valid_in, hcount_in, mapX_in, mapY_in, stepX_in, stepY_in,
    output sideDistX_in, sideDistY_in, deltaDistX_in, deltaDistY_in,
    output map_data, ready_in,
    input  ready_out, map_addr, valid_out, hcount_out, wall_type_out, side_out, perp_dist_out
  );

  modport slave (
`ifdef DDA_STATS_EN
    output step_count_out,
`endif
    input  valid_in, hcount_in, mapX_in, mapY_in, stepX_in, stepY_in,
    input  sideDistX_in, sideDistY_in, deltaDistX_in, deltaDistY_in,
    input  map_data, ready_in,
    output ready_out, map_addr, valid_out, hcount_out, wall_type_out, side_out, perp_dist_out
  );
endinterface

// File: rtl/dda_wall_marcher.sv
// DDA grid walk for one screen column: steps the ray cell by cell, reads the map, reports the wall hit.
// Optional macro DDA_STATS_EN adds step_count_out (steps taken for the current result).
module dda_wall_marcher #(
  parameter int MAP_SIZE    = 24,
  parameter int MAP_LATENCY = 2,
  parameter int MAX_STEPS   = 64,
  parameter int ADDR_W      = $clog2(MAP_SIZE * MAP_SIZE)
) (
  input logic              pixel_clk_in,
  input logic              rst_in,
  dda_wall_marcher_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STEP  = 3'd1,
    FETCH = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0]        MAP_SIZE_B = 8'(MAP_SIZE);
  localparam logic [ADDR_W-1:0] MAP_SIZE_A = ADDR_W'(MAP_SIZE);
  localparam logic [7:0]        MAX_STEP_B = 8'(MAX_STEPS);
  localparam logic [7:0]        LAT_LAST_B = 8'(MAP_LATENCY - 1);

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    sat_add16 = sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  state_t            state_r;
  logic [8:0]        hcount_r;
  logic [7:0]        map_x_r, map_y_r;
  logic              step_x_r, step_y_r;
  logic [15:0]       side_x_r, side_y_r, delta_x_r, delta_y_r;
  logic [15:0]       perp_r;
  logic              side_r;
  logic [7:0]        step_cnt_r;
  logic [7:0]        wait_cnt_r;
  logic              ready_out_r, valid_out_r, side_out_r;
  logic [ADDR_W-1:0] map_addr_r;
  logic [8:0]        hcount_out_r;
  logic [3:0]        wall_out_r;
  logic [15:0]       perp_out_r;
`ifdef DDA_STATS_EN
  logic [7:0]        step_count_out_r;
`endif

  logic              take_x_s, oob_s;
  logic [7:0]        nx_s, ny_s, new_x_s, new_y_s;
  logic [15:0]       chosen_s;
  logic [ADDR_W-1:0] addr_s;

  // Next-cell selection for the STEP state; ties on sideDist go to the Y axis.
  always_comb begin
    take_x_s = 1'b0;
    nx_s     = map_x_r;
    ny_s     = map_y_r;
    new_x_s  = map_x_r;
    new_y_s  = map_y_r;
    chosen_s = side_y_r;
    take_x_s = (side_x_r < side_y_r);
    if (step_x_r) nx_s = map_x_r + 8'd1;
    else          nx_s = map_x_r - 8'd1;
    if (step_y_r) ny_s = map_y_r + 8'd1;
    else          ny_s = map_y_r - 8'd1;
    if (take_x_s) begin
      new_x_s  = nx_s;
      chosen_s = side_x_r;
    end else begin
      new_y_s  = ny_s;
      chosen_s = side_y_r;
    end
    oob_s  = (new_x_s >= MAP_SIZE_B) || (new_y_s >= MAP_SIZE_B);
    addr_s = ADDR_W'(new_y_s) * MAP_SIZE_A + ADDR_W'(new_x_s);
  end

  // Marcher FSM: ray latch, stepping, map-read wait, hit check and result handshake.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state_r      <= IDLE;
      hcount_r     <= 9'd0;
      map_x_r      <= 8'd0;
      map_y_r      <= 8'd0;
      step_x_r     <= 1'b0;
      step_y_r     <= 1'b0;
      side_x_r     <= 16'd0;
      side_y_r     <= 16'd0;
      delta_x_r    <= 16'd0;
      delta_y_r    <= 16'd0;
      perp_r       <= 16'd0;
      side_r       <= 1'b0;
      step_cnt_r   <= 8'd0;
      wait_cnt_r   <= 8'd0;
      ready_out_r  <= 1'b0;
      valid_out_r  <= 1'b0;
      map_addr_r   <= '0;
      hcount_out_r <= 9'd0;
      wall_out_r   <= 4'd0;
      side_out_r   <= 1'b0;
      perp_out_r   <= 16'd0;
`ifdef DDA_STATS_EN
      step_count_out_r <= 8'd0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.valid_in && ready_out_r) begin
            hcount_r    <= bus.hcount_in;
            map_x_r     <= bus.mapX_in;
            map_y_r     <= bus.mapY_in;
            step_x_r    <= bus.stepX_in;
            step_y_r    <= bus.stepY_in;
            side_x_r    <= bus.sideDistX_in;
            side_y_r    <= bus.sideDistY_in;
            delta_x_r   <= bus.deltaDistX_in;
            delta_y_r   <= bus.deltaDistY_in;
            step_cnt_r  <= 8'd0;
            ready_out_r <= 1'b0;
            state_r     <= STEP;
          end else begin
            ready_out_r <= 1'b1;
          end
        end
        STEP: begin
          perp_r     <= chosen_s;
          side_r     <= ~take_x_s;
          map_x_r    <= new_x_s;
          map_y_r    <= new_y_s;
          step_cnt_r <= step_cnt_r + 8'd1;
          if (take_x_s) side_x_r <= sat_add16(side_x_r, delta_x_r);
          else          side_y_r <= sat_add16(side_y_r, delta_y_r);
          // Leaving the map ends the ray without touching map_addr.
          if (oob_s) begin
            hcount_out_r <= hcount_r;
            wall_out_r   <= 4'hF;
            side_out_r   <= ~take_x_s;
            perp_out_r   <= chosen_s;
            valid_out_r  <= 1'b1;
`ifdef DDA_STATS_EN
            step_count_out_r <= step_cnt_r + 8'd1;
`endif
            state_r      <= DONE;
          end else begin
            map_addr_r <= addr_s;
            wait_cnt_r <= 8'd0;
            state_r    <= FETCH;
          end
        end
        FETCH: begin
          if (wait_cnt_r == LAT_LAST_B) state_r <= CHECK;
          else                          wait_cnt_r <= wait_cnt_r + 8'd1;
        end
        CHECK: begin
          if (bus.map_data != 4'd0) begin
            hcount_out_r <= hcount_r;
            wall_out_r   <= bus.map_data;
            side_out_r   <= side_r;
            perp_out_r   <= perp_r;
            valid_out_r  <= 1'b1;
`ifdef DDA_STATS_EN
            step_count_out_r <= step_cnt_r;
`endif
            state_r      <= DONE;
          end else if (step_cnt_r == MAX_STEP_B) begin
            hcount_out_r <= hcount_r;
            wall_out_r   <= 4'd0;
            side_out_r   <= side_r;
            perp_out_r   <= 16'hFFFF;
            valid_out_r  <= 1'b1;
`ifdef DDA_STATS_EN
            step_count_out_r <= step_cnt_r;
`endif
            state_r      <= DONE;
          end else begin
            state_r <= STEP;
          end
        end
        DONE: begin
          if (bus.ready_in) begin
            valid_out_r <= 1'b0;
            ready_out_r <= 1'b1;
            state_r     <= IDLE;
          end else begin
            valid_out_r <= 1'b1;
          end
        end
        default: begin
          valid_out_r <= 1'b0;
          ready_out_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready_out     = ready_out_r;
  assign bus.valid_out     = valid_out_r;
  assign bus.map_addr      = map_addr_r;
  assign bus.hcount_out    = hcount_out_r;
  assign bus.wall_type_out = wall_out_r;
  assign bus.side_out      = side_out_r;
  assign bus.perp_dist_out = perp_out_r;
`ifdef DDA_STATS_EN
  assign bus.step_count_out = step_count_out_r;
`endif

endmodule

// File: doc/dda_wall_marcher.md
Name: dda_wall_marcher

Overview:
- Consumer of the per-column ray setup (rayDir / step / sideDist / deltaDist) produced upstream.
- Runs the DDA grid walk: repeatedly steps the ray one map cell in X or Y and reads the map BRAM after each step.
- Stops when it hits a wall, leaves the map, or exceeds the step limit.
- Returns column index, wall type, hit side and perpendicular wall distance to the column renderer.

Parameters:
- MAP_SIZE, 24, map is MAP_SIZE x MAP_SIZE cells, row-major.
- MAP_LATENCY, 2, cycles from map_addr registered to map_data valid.
- MAX_STEPS, 64, step limit before timeout.
- ADDR_W, $clog2(MAP_SIZE*MAP_SIZE), map address width.

Ports:
- pixel_clk_in  in  1  single clock.
- rst_in  in  1  synchronous, active-high reset.
- valid_in  in  1  ray setup valid.
- ready_out  out  1  high only in IDLE; transfer when valid_in & ready_out.
- hcount_in  in  9  screen column.
- mapX_in, mapY_in  in  8 each  starting cell (floor of pos).
- stepX_in, stepY_in  in  1 each  1 = +1, 0 = -1.
- sideDistX_in, sideDistY_in  in  16 each  unsigned Q8.8.
- deltaDistX_in, deltaDistY_in  in  16 each  unsigned Q8.8.
- map_addr  out  ADDR_W  mapY*MAP_SIZE + mapX, registered.
- map_data  in  4  wall type; 0 = empty.
- valid_out  out  1  result valid; held until ready_in.
- ready_in  in  1  downstream accept.
- hcount_out  out  9  column of result.
- wall_type_out  out  4  hit wall type; 4'hF = out of map; 0 = timeout.
- side_out  out  1  0 = X face, 1 = Y face.
- perp_dist_out  out  16  Q8.8 perpendicular distance.

Behaviour:
- Reset values: ready_out 0 while rst_in high, 1 on the first cycle after; valid_out 0; map_addr 0; all result outputs 0; state IDLE; step counter 0. All inputs are ignored during reset.
- Reset mid-march or mid-output: the ray is aborted and no result is emitted.
- IDLE: on handshake, latch all inputs and clear the step counter, then go to STEP. The starting cell is never checked.
- STEP (1 cycle):
  - If sideDistX < sideDistY (strict): save perp = sideDistX; sideDistX += deltaDistX; mapX += ±1; side = 0.
  - Otherwise (ties go to Y): same operations on the Y registers; side = 1.
  - Additions saturate at 16'hFFFF. Map coordinates are 8-bit and wrap (0 - 1 = 255).
  - Increment the step counter.
  - If the new mapX or mapY is >= MAP_SIZE: result wall 4'hF, go to DONE with no read issued.
  - Otherwise register map_addr and go to FETCH.
- FETCH: wait MAP_LATENCY cycles, then go to CHECK.
- CHECK (1 cycle):
  - map_data != 0: result wall = map_data, go to DONE.
  - Else if step counter == MAX_STEPS: wall 0, perp 16'hFFFF, go to DONE.
  - Else go to STEP.
- Per-step cost is MAP_LATENCY + 2 cycles.
- DONE: drive valid_out with hcount, wall, side and perp (the chosen sideDist value before the final add).
  - Outputs are stable while valid_out & ~ready_in.
  - On ready_in, go to IDLE; valid_out falls the next cycle.
- There is no overlap between rays: ready_out stays low from acceptance until the result is taken.

Optional Feature:
- Macro DDA_STATS_EN.
- Defined: adds output step_count_out [7:0]. It equals the number of steps taken for the current result and is valid with valid_out. It resets to 0.
- Undefined: the port is absent and there is no extra logic.

Test Plan:
- Empty interior, border walls type 1, MAP_LATENCY 2. Start (12,12), stepX 1, sideDistX 0x0080, deltaDistX 0x0100, sideDistY = deltaDistY = 0xFFFF -> 11 X-steps; result wall 1, side 0, perp 0x0A80, hcount echoed; valid_out 44 cycles after acceptance.
- Tie: start (12,12), both steps +1, sideDist X/Y 0x0100, deltaDist 0x0100; wall 2 at (13,12), wall 3 at (12,13) -> wall 3, side 1, perp 0x0100.
- No border, start (0,5), stepX 0, sideDistX 0x0040 < sideDistY -> wall 4'hF, side 0, perp 0x0040, valid after 1 step; map_addr never changes from its prior value.
- MAX_STEPS 4, fully empty map, start (12,12) -> wall 0, perp 0xFFFF after exactly 4 steps.
- Backpressure: result valid, ready_in low for 10 cycles -> valid_out and outputs held, ready_out 0. Then ready_in 1 -> accepted; ready_out 1 next cycle.
- rst_in pulsed during FETCH -> valid_out stays 0, ready_out 1 after reset, a new ray completes correctly. With DDA_STATS_EN, scenario 1 reports step_count_out 11.
